fsm_moesi_controler: RTL and testbench



---
 rtl/fsm_moesi_controler.sv | 148 ++++++++++++++
 tb/tb_fsm_moesi_controler.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fsm_moesi_controler.sv
// MOESI coherency decision block: CPU-side and snoop-side decodes, both registered.
// Optional build macro MOESI_E_INTERVENTION_EN: EXCLUSIVE line supplies data on a snooped read.
module fsm_moesi_controler #(
    parameter logic [2:0] INVALID   = 3'b000,
    parameter logic [2:0] MODIFIED  = 3'b001,
    parameter logic [2:0] SHARED    = 3'b010,
    parameter logic [2:0] OWNED     = 3'b011,
    parameter logic [2:0] EXCLUSIVE = 3'b100,
    parameter logic [2:0] FROM_M    = 3'b001,
    parameter logic [2:0] FROM_O    = 3'b011,
    parameter logic [2:0] FROM_E    = 3'b100,
    parameter logic [2:0] FROM_MEM  = 3'b101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] coherency_state_attending_cpu,
    input  logic       cpu_write_hit,
    input  logic       cpu_read_hit,
    input  logic       cpu_write_miss,
    input  logic       cpu_read_miss,
    input  logic [2:0] coherency_state_attending_bus,
    input  logic [2:0] bus_from_state,
    input  logic       bus_read,
    input  logic       bus_rwitm,
    input  logic       bus_invalidate,
    input  logic       bus_shared,
    output logic [2:0] cpu_next_state,
    output logic [2:0] bus_next_state,
    output logic       read,
    output logic       rwitm,
    output logic       invalidate,
    output logic       shared,
    output logic       abort_mem_access_next
);

`ifdef MOESI_E_INTERVENTION_EN
    localparam logic E_ABORT = 1'b1;
`else
    localparam logic E_ABORT = 1'b0;
`endif

    // Encodings above EXCLUSIVE are not legal states and collapse to INVALID.
    function automatic logic [2:0] legal_state(input logic [2:0] s);
        return (s > EXCLUSIVE) ? INVALID : s;
    endfunction

    logic [2:0] cpu_state, bus_state;
    logic       from_cache, fill_exclusive;
    logic [2:0] cpu_next_state_reg, cpu_next_state_next;
    logic [2:0] bus_next_state_reg, bus_next_state_next;
    logic       read_reg, read_next;
    logic       rwitm_reg, rwitm_next;
    logic       invalidate_reg, invalidate_next;
    logic       shared_reg, shared_next;
    logic       abort_reg, abort_next;

    assign cpu_state  = legal_state(coherency_state_attending_cpu);
    assign bus_state  = legal_state(coherency_state_attending_bus);
    assign from_cache = (bus_from_state == FROM_M) || (bus_from_state == FROM_O) ||
                        (bus_from_state == FROM_E);
    assign fill_exclusive = !from_cache && (bus_from_state == FROM_MEM) && !bus_shared;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_next_state_reg <= INVALID;
            bus_next_state_reg <= INVALID;
            read_reg           <= 1'b0;
            rwitm_reg          <= 1'b0;
            invalidate_reg     <= 1'b0;
            shared_reg         <= 1'b0;
            abort_reg          <= 1'b0;
        end else begin
            cpu_next_state_reg <= cpu_next_state_next;
            bus_next_state_reg <= bus_next_state_next;
            read_reg           <= read_next;
            rwitm_reg          <= rwitm_next;
            invalidate_reg     <= invalidate_next;
            shared_reg         <= shared_next;
            abort_reg          <= abort_next;
        end
    end

    // CPU side: write miss > read miss > write hit > read hit; hits in I behave as misses.
    always_comb begin
        cpu_next_state_next = cpu_state;
        read_next           = 1'b0;
        rwitm_next          = 1'b0;
        invalidate_next     = 1'b0;
        if (cpu_write_miss) begin
            rwitm_next          = 1'b1;
            cpu_next_state_next = MODIFIED;
        end else if (cpu_read_miss) begin
            read_next           = 1'b1;
            cpu_next_state_next = fill_exclusive ? EXCLUSIVE : SHARED;
        end else if (cpu_write_hit) begin
            cpu_next_state_next = MODIFIED;
            if (cpu_state == INVALID)
                rwitm_next = 1'b1;
            else if (cpu_state == SHARED || cpu_state == OWNED)
                invalidate_next = 1'b1;
        end else if (cpu_read_hit && cpu_state == INVALID) begin
            read_next           = 1'b1;
            cpu_next_state_next = fill_exclusive ? EXCLUSIVE : SHARED;
        end
    end

    // Snoop side: rwitm > invalidate > read.
    always_comb begin
        bus_next_state_next = bus_state;
        shared_next         = 1'b0;
        abort_next          = 1'b0;
        if (bus_rwitm) begin
            bus_next_state_next = INVALID;
            abort_next = (bus_state == MODIFIED) || (bus_state == OWNED) ||
                         (bus_state == EXCLUSIVE);
        end else if (bus_invalidate) begin
            bus_next_state_next = INVALID;
        end else if (bus_read) begin
            case (bus_state)
                MODIFIED: begin
                    bus_next_state_next = OWNED;
                    shared_next = 1'b1;
                    abort_next  = 1'b1;
                end
                OWNED: begin
                    shared_next = 1'b1;
                    abort_next  = 1'b1;
                end
                EXCLUSIVE: begin
                    bus_next_state_next = SHARED;
                    shared_next = 1'b1;
                    abort_next  = E_ABORT;
                end
                SHARED:  shared_next = 1'b1;
                default: ;
            endcase
        end
    end

    assign cpu_next_state        = cpu_next_state_reg;
    assign bus_next_state        = bus_next_state_reg;
    assign read                  = read_reg;
    assign rwitm                 = rwitm_reg;
    assign invalidate            = invalidate_reg;
    assign shared                = shared_reg;
    assign abort_mem_access_next = abort_reg;

endmodule

// File: tb/tb_fsm_moesi_controler.sv
// Scoreboard bench for fsm_moesi_controler: directed vectors, expected responses queued.
module tb_fsm_moesi_controler;
    localparam logic [2:0] I = 3'b000, M = 3'b001, S = 3'b010, O = 3'b011, E = 3'b100;
    localparam logic [2:0] FM = 3'b001, FO = 3'b011, FMEM = 3'b101;
`ifdef MOESI_E_INTERVENTION_EN
    localparam logic E_AB = 1'b1;
`else
    localparam logic E_AB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cst = 3'b0, bst = 3'b0, from = 3'b0;
    logic       wh = 0, rh = 0, wm = 0, rm = 0, br = 0, brw = 0, binv = 0, bsh = 0;
    logic [2:0] cpu_next_state, bus_next_state;
    logic       read, rwitm, invalidate, shared, abort_mem_access_next;

    int n_cmp = 0, n_bad = 0;
    logic [10:0] exp_q[$];
    string       name_q[$];

    fsm_moesi_controler dut (
        .clk(clk), .rst_n(rst_n),
        .coherency_state_attending_cpu(cst),
        .cpu_write_hit(wh), .cpu_read_hit(rh), .cpu_write_miss(wm), .cpu_read_miss(rm),
        .coherency_state_attending_bus(bst), .bus_from_state(from),
        .bus_read(br), .bus_rwitm(brw), .bus_invalidate(binv), .bus_shared(bsh),
        .cpu_next_state(cpu_next_state), .bus_next_state(bus_next_state),
        .read(read), .rwitm(rwitm), .invalidate(invalidate), .shared(shared),
        .abort_mem_access_next(abort_mem_access_next)
    );

    always #5 clk = ~clk;

    // Packed response: {cpu_ns, bus_ns, read, rwitm, invalidate, shared, abort}
    function automatic logic [10:0] outs();
        return {cpu_next_state, bus_next_state, read, rwitm, invalidate, shared,
                abort_mem_access_next};
    endfunction

    task automatic check(input string nm, input logic [10:0] want);
        logic [10:0] got;
        got = outs();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", nm, got, want);
        end else begin
            $display("ok   %s: %b", nm, got);
        end
    endtask

    // cpu: state wm rm wh rh from bsh ; bus: state rwitm inv read ; expected fields
    task automatic drive(input string nm,
                         input logic [2:0] c, input logic iwm, irm, iwh, irh,
                         input logic [2:0] f, input logic ish,
                         input logic [2:0] b, input logic irw, iinv, ird,
                         input logic [2:0] ecpu, ebus,
                         input logic erd, erw, einv, esh, eab);
        @(negedge clk);
        cst = c; wm = iwm; rm = irm; wh = iwh; rh = irh; from = f; bsh = ish;
        bst = b; brw = irw; binv = iinv; br = ird;
        exp_q.push_back({ecpu, ebus, erd, erw, einv, esh, eab});
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are valid every cycle, compared #1 after the edge.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check(name_q.pop_front(), exp_q.pop_front());
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 check("reset_state", 11'b0);
        @(negedge clk) rst_n = 1'b1;

        drive("rdmiss_mem_excl", I,0,1,0,0, FMEM,0, I,0,0,0, E,I, 1,0,0,0,0);
        drive("rdmiss_fromM_sh", I,0,1,0,0, FM,0,   I,0,0,0, S,I, 1,0,0,0,0);
        drive("wrhit_S",         S,0,0,1,0, FMEM,0, I,0,0,0, M,I, 0,0,1,0,0);
        drive("wrhit_E",         E,0,0,1,0, FMEM,0, I,0,0,0, M,I, 0,0,0,0,0);
        drive("snp_rd_M",        O,0,0,0,0, FMEM,0, M,0,0,1, O,O, 0,0,0,1,1);
        drive("snp_rwitm_rd_O",  I,0,0,0,0, FMEM,0, O,1,0,1, I,I, 0,0,0,0,1);
        drive("wrmiss_E",        E,1,0,0,0, FMEM,0, S,0,0,0, M,S, 0,1,0,0,0);
        drive("wrhit_I",         I,0,0,1,0, FMEM,0, E,0,0,0, M,E, 0,1,0,0,0);
        drive("rdhit_O",         O,0,0,0,1, FMEM,0, I,0,0,1, O,I, 0,0,0,0,0);
        drive("rdhit_I_shared",  I,0,0,0,1, FMEM,1, S,0,0,1, S,S, 1,0,0,1,0);
        drive("undef_states",    3'b110,0,0,0,0, FMEM,0, 3'b111,0,0,1, I,I, 0,0,0,0,0);
        drive("snp_rd_E",        M,0,0,0,0, FMEM,0, E,0,0,1, M,S, 0,0,0,1,E_AB);
        drive("snp_inv_rd_M",    S,0,0,0,0, FMEM,0, M,0,1,1, S,I, 0,0,0,0,0);
        drive("snp_rwitm_S",     I,0,0,0,0, FMEM,0, S,1,0,0, I,I, 0,0,0,0,0);
        drive("snp_rwitm_I",     I,0,0,0,0, FMEM,0, I,1,0,0, I,I, 0,0,0,0,0);
        drive("snp_rwitm_E",     I,0,0,0,0, FMEM,0, E,1,0,0, I,I, 0,0,0,0,1);
        drive("prio_wm_over_rm", S,1,1,1,1, FMEM,0, I,0,0,0, M,I, 0,1,0,0,0);
        drive("prio_rm_over_wh", M,0,1,1,0, FO,0,   I,0,0,0, S,I, 1,0,0,0,0);
        drive("wrhit_O_snp_rdS", O,0,0,1,0, FMEM,0, S,0,0,1, M,S, 0,0,1,1,0);
        drive("snp_rd_M_again",  O,0,0,1,0, FMEM,0, M,0,0,1, M,O, 0,0,1,1,1);

        // Asynchronous reset while outputs are active, inputs held.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset_midcycle", 11'b0);
        @(posedge clk);
        #1 check("reset_held_inputs_active", 11'b0);
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back({M, O, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        name_q.push_back("first_decode_after_reset");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
